// File: rtl/prio_stim_gen_if.sv
// rtl/prio_stim_gen_if.sv - run-control, stimulus and response bundle for prio_stim_gen
interface prio_stim_gen_if #(
    parameter int IN_W    = 24,
    parameter int OUT_W   = 25,
    parameter int STEPS_W = 16
);
    logic               start;
    logic [STEPS_W-1:0] num_steps;
    logic [IN_W-1:0]    stim;
    logic [OUT_W-1:0]   resp;
    logic               resp_vld;
    logic [STEPS_W-1:0] step_idx;
    logic               busy;
    logic               done;
    logic [OUT_W-1:0]   sig;

    modport master (
        output start, num_steps, resp,
        input  stim, resp_vld, step_idx, busy, done, sig
    );

    modport slave (
        input  start, num_steps, resp,
        output stim, resp_vld, step_idx, busy, done, sig
    );
endinterface

// File: rtl/prio_stim_gen.sv
// rtl/prio_stim_gen.sv - priority-group stimulus engine with optional MISR (PRIO_STIM_MISR_EN)
module prio_stim_gen #(
    parameter int                 IN_W     = 24,
    parameter int                 OUT_W    = 25,
    parameter int                 NGRP     = 3,
    parameter logic [4*NGRP-1:0]  PER_LOG2 = {4'd6, 4'd5, 4'd1},
    parameter int                 STEPS_W  = 16,
    parameter int                 SETTLE   = 1,
    parameter logic [OUT_W-1:0]   POLY     = 25'h1000009
) (
    input  logic           clk,
    input  logic           rst_n,
    prio_stim_gen_if.slave bus
);
    localparam int GW     = IN_W / NGRP;
    localparam int SCNT_W = $clog2(SETTLE + 2);
    // Wide enough that shifting by any 4-bit period exponent reads zeros above STEPS_W.
    localparam int EXT_W  = STEPS_W + GW + 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state;
    logic [STEPS_W-1:0] n_q;
    logic [STEPS_W-1:0] step_q;
    logic [SCNT_W-1:0]  settle_cnt;
    logic [IN_W-1:0]    stim_q;
    logic [IN_W-1:0]    stim_next;
    logic [EXT_W-1:0]   step_ext;
    logic [3:0]         per;
    logic               resp_vld_q;
    logic               busy_q;
    logic               done_q;

    always_comb begin
        stim_next = stim_q;
        step_ext  = EXT_W'(step_q);
        per       = '0;
        for (int g = 0; g < NGRP; g++) begin
            per = PER_LOG2[4*g +: 4];
            if ((step_ext & ((EXT_W'(1) << per) - EXT_W'(1))) == '0)
                stim_next[g*GW +: GW] = GW'(step_ext >> per);
        end
    end

`ifdef PRIO_STIM_MISR_EN
    logic [OUT_W-1:0] sig_q;
    logic [OUT_W-1:0] misr_next;

    assign misr_next = {sig_q[OUT_W-2:0], ^(sig_q & POLY)} ^ bus.resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= '0;
        end else if (state == S_IDLE && bus.start) begin
            sig_q <= '0;
        end else if (state == S_SAMPLE) begin
            sig_q <= misr_next;
        end
    end

    assign bus.sig = sig_q;
`else
    assign bus.sig = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            n_q        <= '0;
            step_q     <= '0;
            settle_cnt <= '0;
            stim_q     <= '0;
            resp_vld_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            resp_vld_q <= 1'b0;
            done_q     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        n_q    <= bus.num_steps;
                        step_q <= '0;
                        stim_q <= '0;
                        busy_q <= 1'b1;
                        if (bus.num_steps == '0) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else begin
                            state <= S_APPLY;
                        end
                    end
                end
                S_APPLY: begin
                    stim_q     <= stim_next;
                    settle_cnt <= '0;
                    if (SETTLE == 0) begin
                        state      <= S_SAMPLE;
                        resp_vld_q <= 1'b1;
                    end else begin
                        state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SCNT_W'(SETTLE - 1)) begin
                        state      <= S_SAMPLE;
                        resp_vld_q <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SCNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (step_q == n_q - STEPS_W'(1)) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                    end else begin
                        step_q <= step_q + STEPS_W'(1);
                        state  <= S_APPLY;
                    end
                end
                S_DONE: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.stim     = stim_q;
    assign bus.resp_vld = resp_vld_q;
    assign bus.step_idx = step_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
